// File: rtl/idexe_elastic_stage.sv
// rtl/idexe_elastic_stage.sv - elastic ID/EXE issue-group register with 2-entry skid buffer
// HEAD drives the outputs directly; SKID absorbs the one group accepted while EXE stalls.
module idexe_elastic_stage #(
   parameter int LANES    = 2,
   parameter int LANE_W   = 136,
   parameter int SHARED_W = 48,
   parameter int CNT_W    = 32
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES-1:0]          in_lane_vld,
   input  logic [LANES*LANE_W-1:0]   in_payload,
   input  logic [SHARED_W-1:0]       in_shared,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES-1:0]          out_lane_vld,
   output logic [LANES*LANE_W-1:0]   out_payload,
   output logic [SHARED_W-1:0]       out_shared,
   input  logic                      squash_young,
   output logic [CNT_W-1:0]          stall_cnt
);

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   state_t                    state_q, state_d;
   logic [LANES-1:0]          hlv_q, hlv_d, slv_q, slv_d;
   logic [LANES*LANE_W-1:0]   hpay_q, hpay_d, spay_q, spay_d;
   logic [SHARED_W-1:0]       hsh_q, hsh_d, ssh_q, ssh_d;
   logic                      ready_q, ready_d;
   logic [CNT_W-1:0]          stall_q, stall_d;
   logic                      acc, deq, head_vld;

   assign head_vld = (state_q != S_EMPTY);

   always_comb begin
      state_d = state_q;
      hlv_d   = hlv_q;
      hpay_d  = hpay_q;
      hsh_d   = hsh_q;
      slv_d   = slv_q;
      spay_d  = spay_q;
      ssh_d   = ssh_q;
      stall_d = stall_q;
      acc     = in_valid & ready_q & (|in_lane_vld);
      deq     = head_vld & out_ready;

      unique case (state_q)
         S_EMPTY: begin
            if (acc) begin
               state_d = S_ONE;
               hlv_d   = in_lane_vld;
               hpay_d  = in_payload;
               hsh_d   = in_shared;
            end
         end
         S_ONE: begin
            if (acc && deq) begin
               hlv_d  = in_lane_vld;
               hpay_d = in_payload;
               hsh_d  = in_shared;
            end else if (acc) begin
               state_d = S_TWO;
               slv_d   = in_lane_vld;
               spay_d  = in_payload;
               ssh_d   = in_shared;
            end else if (deq) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (deq) begin
               state_d = S_ONE;
               hlv_d   = slv_q;
               hpay_d  = spay_q;
               hsh_d   = ssh_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase

      // Squash only touches a head that is staying put; lane 0 is always kept.
      if (squash_young && head_vld && !deq && !flush) begin
         for (int i = 1; i < LANES; i++) begin
            hlv_d[i]                   = 1'b0;
            hpay_d[i*LANE_W +: LANE_W] = '0;
         end
      end

      // Zeroed storage decodes as NOP / write-disable / no exception downstream.
      if (flush) begin
         state_d = S_EMPTY;
         hlv_d   = '0;
         hpay_d  = '0;
         hsh_d   = '0;
         slv_d   = '0;
         spay_d  = '0;
         ssh_d   = '0;
      end

      ready_d = (state_d != S_TWO);

      if (head_vld && !out_ready && !(&stall_q))
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_EMPTY;
         hlv_q   <= '0;
         hpay_q  <= '0;
         hsh_q   <= '0;
         slv_q   <= '0;
         spay_q  <= '0;
         ssh_q   <= '0;
         ready_q <= 1'b1;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         hlv_q   <= hlv_d;
         hpay_q  <= hpay_d;
         hsh_q   <= hsh_d;
         slv_q   <= slv_d;
         spay_q  <= spay_d;
         ssh_q   <= ssh_d;
         ready_q <= ready_d;
         stall_q <= stall_d;
      end
   end

   assign in_ready     = ready_q;
   assign out_valid    = head_vld;
   assign out_lane_vld = hlv_q;
   assign out_payload  = hpay_q;
   assign out_shared   = hsh_q;
   assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_idexe_elastic_stage.sv
// tb/tb_idexe_elastic_stage.sv - randomized scoreboard bench for idexe_elastic_stage
module tb_idexe_elastic_stage;

   localparam int LN = 2;
   localparam int LW = 16;
   localparam int SW = 8;
   localparam int CW = 4;

   typedef struct {
      logic [LN-1:0]    lv;
      logic [LN*LW-1:0] pay;
      logic [SW-1:0]    sh;
   } grp_t;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [LN-1:0]    in_lane_vld = '0;
   logic [LN*LW-1:0] in_payload = '0;
   logic [SW-1:0]    in_shared = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [LN-1:0]    out_lane_vld;
   logic [LN*LW-1:0] out_payload;
   logic [SW-1:0]    out_shared;
   logic             squash_young = 1'b0;
   logic [CW-1:0]    stall_cnt;

   int   total = 0;
   int   bad = 0;
   int   mstall = 0;
   grp_t mq[$];
   grp_t sb[$];

   idexe_elastic_stage #(.LANES(LN), .LANE_W(LW), .SHARED_W(SW), .CNT_W(CW)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_lane_vld(in_lane_vld),
      .in_payload(in_payload), .in_shared(in_shared),
      .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
      .out_payload(out_payload), .out_shared(out_shared),
      .squash_young(squash_young), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: the stage is a FIFO of at most two groups; ready means fewer than two held.
   task automatic step(input logic v, input logic [LN-1:0] lv, input logic [LN*LW-1:0] pay,
                       input logic [SW-1:0] sh, input logic ordy, input logic fl, input logic sq);
      grp_t g;
      logic acc, deq;
      @(negedge clk);
      in_valid = v; in_lane_vld = lv; in_payload = pay; in_shared = sh;
      out_ready = ordy; flush = fl; squash_young = sq;
      #1;
      chk("in_ready", in_ready, mq.size() < 2);
      chk("out_valid", out_valid, mq.size() > 0);
      chk("stall_cnt", stall_cnt, mstall);
      if (mq.size() > 0) begin
         chk("head_lv", out_lane_vld, mq[0].lv);
         chk("head_pay", out_payload, mq[0].pay);
         chk("head_sh", out_shared, mq[0].sh);
      end
      acc = v && (mq.size() < 2) && (lv != 0);
      deq = (mq.size() > 0) && ordy;
      if (mq.size() > 0 && !ordy && mstall < (1 << CW) - 1) mstall++;
      if (deq) begin
         g = mq.pop_front();
         sb.push_back(g);
      end
      if (fl) begin
         mq.delete();
      end else begin
         if (sq && !deq && mq.size() > 0) begin
            g = mq[0];
            for (int i = 1; i < LN; i++) begin
               g.lv[i] = 1'b0;
               g.pay[i*LW +: LW] = '0;
            end
            mq[0] = g;
         end
         if (acc) begin
            g.lv = lv; g.pay = pay; g.sh = sh;
            mq.push_back(g);
         end
      end
   endtask

   task automatic peek();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      mq.delete();
      sb.delete();
      mstall = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 0; in_lane_vld = '0; out_ready = 0; flush = 0; squash_young = 0;
      resetn = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_payload", out_payload, 0);
      chk("rst_lane_vld", out_lane_vld, 0);
      chk("rst_shared", out_shared, 0);
      chk("rst_stall", stall_cnt, 0);
      @(negedge clk);
      resetn = 1;
      model_clear();
   endtask

   // Monitor: every group EXE actually consumes must match the next expected one.
   initial begin : monitor
      grp_t g;
      forever begin
         @(negedge clk);
         #2;
         if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("mon_unexpected", 1, 0);
            end else begin
               g = sb.pop_front();
               chk("mon_lv", out_lane_vld, g.lv);
               chk("mon_pay", out_payload, g.pay);
               chk("mon_sh", out_shared, g.sh);
            end
         end
      end
   end

   initial begin : stim
      do_reset();

      // Streaming at full rate
      for (int k = 1; k <= 8; k++) step(1, 2'b11, 32'(k), 8'(k), 1, 0, 0);
      step(0, 2'b00, 0, 0, 1, 0, 0);
      peek();
      chk("stream_stall", stall_cnt, 0);
      chk("stream_drain", sb.size(), 0);

      // Back-pressure: A held, B in skid, C refused until room
      do_reset();
      step(1, 2'b11, 32'hA0A0_A0A0, 8'hAA, 0, 0, 0);
      step(1, 2'b11, 32'hB0B0_B0B0, 8'hBB, 0, 0, 0);
      step(1, 2'b11, 32'hC0C0_C0C0, 8'hCC, 0, 0, 0);
      peek();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_head", out_payload, 32'hA0A0_A0A0);
      step(1, 2'b11, 32'hC0C0_C0C0, 8'hCC, 0, 0, 0);
      step(1, 2'b11, 32'hC0C0_C0C0, 8'hCC, 1, 0, 0);
      step(1, 2'b11, 32'hC0C0_C0C0, 8'hCC, 1, 0, 0);
      step(0, 2'b00, 0, 0, 1, 0, 0);
      step(0, 2'b00, 0, 0, 1, 0, 0);
      peek();
      chk("bp_stall", stall_cnt, 3);

      // Flush while full with a group offered
      do_reset();
      step(1, 2'b11, 32'h1111_2222, 8'h11, 0, 0, 0);
      step(1, 2'b11, 32'h3333_4444, 8'h22, 0, 0, 0);
      step(1, 2'b11, 32'h5555_6666, 8'h33, 0, 1, 0);
      peek();
      chk("flush_valid", out_valid, 0);
      chk("flush_pay", out_payload, 0);
      chk("flush_lv", out_lane_vld, 0);
      chk("flush_sh", out_shared, 0);
      chk("flush_ready", in_ready, 1);

      // Squash younger lane of a stalled head
      do_reset();
      step(1, 2'b11, 32'hBEEF_CAFE, 8'h5A, 0, 0, 0);
      step(0, 2'b00, 0, 0, 0, 0, 1);
      peek();
      chk("squash_lv", out_lane_vld, 2'b01);
      chk("squash_lane1", out_payload[31:16], 0);
      chk("squash_lane0", out_payload[15:0], 16'hCAFE);

      // Bubble is never stored
      do_reset();
      step(1, 2'b00, 32'hDEAD_0001, 8'h01, 1, 0, 0);
      peek();
      chk("bubble_valid", out_valid, 0);
      chk("bubble_ready", in_ready, 1);

      // Asynchronous reset pulse between edges while full, then saturation
      do_reset();
      step(1, 2'b11, 32'h0000_0007, 8'h07, 0, 0, 0);
      step(1, 2'b10, 32'h0000_0008, 8'h08, 0, 0, 0);
      @(posedge clk);
      #2;
      resetn = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_pay", out_payload, 0);
      chk("arst_lv", out_lane_vld, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_stall", stall_cnt, 0);
      #1;
      resetn = 1;
      model_clear();
      step(1, 2'b01, 32'h0000_0009, 8'h09, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 2'b00, 0, 0, 0, 0, 0);
      peek();
      chk("sat_stall", stall_cnt, 15);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 7, LN'($urandom), $urandom, SW'($urandom),
              $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0);
      end
      step(0, 2'b00, 0, 0, 1, 0, 0);
      step(0, 2'b00, 0, 0, 1, 0, 0);
      step(0, 2'b00, 0, 0, 1, 0, 0);
      peek();
      chk("final_drain", sb.size(), 0);
      chk("final_empty", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
